shift_seq_unit: RTL and testbench



---
 rtl/shift_seq_unit_pkg.sv | 25 ++
 rtl/shift_seq_unit_if.sv | 25 ++
 rtl/shift_seq_unit_step.sv | 47 ++++
 rtl/shift_seq_unit.sv | 129 ++++++++++++
 tb/tb_shift_seq_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_unit_pkg.sv
// Shared definitions for the iterative shift/rotate unit: operation codes,
// controller state encodings and the effective shift-count helper.
package shift_seq_unit_pkg;

    localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
    localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
    localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
    localparam logic [1:0] SHIFT_OP_ROR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Shifts saturate at 8 positions; rotates wrap modulo 8.
    function automatic logic [3:0] eff_count(input logic [1:0] op, input logic [7:0] amt);
        if (op == SHIFT_OP_ROR) begin
            return {1'b0, amt[2:0]};
        end else if (amt > 8'd8) begin
            return 4'd8;
        end else begin
            return amt[3:0];
        end
    endfunction

endpackage

// File: rtl/shift_seq_unit_if.sv
// Request/response bundle of shift_seq_unit. The ZERO/COUT flag signals only
// exist when SHIFT_SEQ_FLAGS_EN is defined.
interface shift_seq_unit_if;
    logic       START;
    logic [1:0] OP;
    logic [7:0] DATA;
    logic [7:0] SHIFT;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
`ifdef SHIFT_SEQ_FLAGS_EN
    logic       ZERO;
    logic       COUT;

    modport master (output START, OP, DATA, SHIFT,
                    input  BUSY, DONE, RESULT, ZERO, COUT);
    modport slave  (input  START, OP, DATA, SHIFT,
                    output BUSY, DONE, RESULT, ZERO, COUT);
`else
    modport master (output START, OP, DATA, SHIFT,
                    input  BUSY, DONE, RESULT);
    modport slave  (input  START, OP, DATA, SHIFT,
                    output BUSY, DONE, RESULT);
`endif
endinterface

// File: rtl/shift_seq_unit_step.sv
// shift_step: combinational single-cycle shift of an 8-bit value by 0..7
// positions. fill_i is the sign bit used for SRA. With SHIFT_SEQ_FLAGS_EN
// the last bit shifted out (new bit 7 for ROR) is also reported.
module shift_step
    import shift_seq_unit_pkg::*;
(
    input  logic [7:0] value_i,
    input  logic [1:0] op_i,
    input  logic [2:0] amt_i,
    input  logic       fill_i,
`ifdef SHIFT_SEQ_FLAGS_EN
    output logic       cout_o,
`endif
    output logic [7:0] value_o
);

    logic       fill_bit;
    logic       cout_w;
    logic [7:0] fill_mask;

    // Select the shifted value and the last bit that left the word.
    always_comb begin
        fill_bit  = (op_i == SHIFT_OP_SRA) ? fill_i : 1'b0;
        fill_mask = fill_bit ? ~(8'hFF >> amt_i) : 8'h00;
        value_o   = value_i;
        cout_w    = 1'b0;
        case (op_i)
            SHIFT_OP_SLL: begin
                value_o = value_i << amt_i;
                if (amt_i != 3'd0) cout_w = value_i[3'(4'd8 - {1'b0, amt_i})];
            end
            SHIFT_OP_SRL, SHIFT_OP_SRA: begin
                value_o = (value_i >> amt_i) | fill_mask;
                if (amt_i != 3'd0) cout_w = value_i[amt_i - 3'd1];
            end
            default: begin
                value_o = (value_i >> amt_i) | (value_i << (4'd8 - {1'b0, amt_i}));
                if (amt_i != 3'd0) cout_w = value_i[amt_i - 3'd1];
            end
        endcase
    end

`ifdef SHIFT_SEQ_FLAGS_EN
    assign cout_o = cout_w;
`endif

endmodule

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: iterative shift/rotate unit, up to STEP positions per cycle.
// Optional flags (ZERO, COUT) are compiled in with SHIFT_SEQ_FLAGS_EN.
//
// state | meaning
// IDLE  | waiting for START; RESULT holds the last completed value
// RUN   | shifting by min(CNT, STEP) each cycle, BUSY high
// FIN   | DONE pulse for one cycle, RESULT final
module shift_seq_unit
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    shift_seq_unit_if.slave  bus
);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, done_q;
    logic [2:0]       k;
    logic [7:0]       step_val;
`ifdef SHIFT_SEQ_FLAGS_EN
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             step_cout;
`endif

    // Positions to shift this cycle: the remaining count, capped at STEP.
    always_comb begin
        k = (cnt_q > 4'(STEP)) ? 3'(STEP) : cnt_q[2:0];
    end

    shift_step u_step (
        .value_i (result_q),
        .op_i    (op_q),
        .amt_i   (k),
        .fill_i  (sign_q),
`ifdef SHIFT_SEQ_FLAGS_EN
        .cout_o  (step_cout),
`endif
        .value_o (step_val)
    );

    // Next-state logic for the controller and the working register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        result_d = result_q;
`ifdef SHIFT_SEQ_FLAGS_EN
        zero_d   = zero_q;
        cout_d   = cout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    result_d = bus.DATA;
                    op_d     = bus.OP;
                    sign_d   = bus.DATA[7];
                    cnt_d    = eff_count(bus.OP, bus.SHIFT);
                    state_d  = (cnt_d != 4'd0) ? ST_RUN : ST_FIN;
`ifdef SHIFT_SEQ_FLAGS_EN
                    zero_d   = 1'b0;
                    cout_d   = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                result_d = step_val;
                cnt_d    = cnt_q - {1'b0, k};
`ifdef SHIFT_SEQ_FLAGS_EN
                cout_d   = step_cout;
`endif
                if (cnt_d == 4'd0) state_d = ST_FIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef SHIFT_SEQ_FLAGS_EN
        // ZERO is decided on entry to FIN and held until the next accepted START.
        if (state_d == ST_FIN && state_q != ST_FIN) zero_d = (result_d == '0);
`endif
    end

    // State registers; BUSY/DONE are registered decodes of the next state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            op_q     <= SHIFT_OP_SLL;
            sign_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SHIFT_SEQ_FLAGS_EN
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            busy_q   <= (state_d == ST_RUN);
            done_q   <= (state_d == ST_FIN);
`ifdef SHIFT_SEQ_FLAGS_EN
            zero_q   <= zero_d;
            cout_q   <= cout_d;
`endif
        end
    end

    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;
`ifdef SHIFT_SEQ_FLAGS_EN
    assign bus.ZERO   = zero_q;
    assign bus.COUT   = cout_q;
`endif

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: one instance with STEP=1 and one with
// STEP=3. Stimulus pushes expected responses; per-unit monitors pop on DONE.
module tb_shift_seq_unit;

    typedef struct {
        logic [7:0] res;
        int         lat;
        int         busy;
        logic       z;
        logic       c;
        int         t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_n1 = 0;
    int   busy_n3 = 0;
    exp_t q1[$];
    exp_t q3[$];

    shift_seq_unit_if if1();
    shift_seq_unit_if if3();

    shift_seq_unit #(.WIDTH(8), .STEP(1)) dut1 (.CLK(clk), .RESET(rst1), .bus(if1));
    shift_seq_unit #(.WIDTH(8), .STEP(3)) dut3 (.CLK(clk), .RESET(rst3), .bus(if3));

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic score(input int u, input logic [7:0] res, input logic z, input logic c,
                         input int busy_n);
        exp_t e;
        int   sz;
        sz = (u == 1) ? q1.size() : q3.size();
        chk($sformatf("u%0d_done_expected", u), (sz > 0), 1);
        if (sz > 0) begin
            if (u == 1) e = q1.pop_front(); else e = q3.pop_front();
            chk($sformatf("u%0d_result", u), res, e.res);
            chk($sformatf("u%0d_latency", u), cyc - e.t0 + 1, e.lat);
            chk($sformatf("u%0d_busy_cycles", u), busy_n, e.busy);
`ifdef SHIFT_SEQ_FLAGS_EN
            chk($sformatf("u%0d_zero", u), z, e.z);
            chk($sformatf("u%0d_cout", u), c, e.c);
`endif
        end
    endtask

    // Monitor for the STEP=1 unit.
    initial forever begin
        @(negedge clk);
        if (!rst1) begin
            if (if1.BUSY) busy_n1++;
            if (if1.DONE) begin
`ifdef SHIFT_SEQ_FLAGS_EN
                score(1, if1.RESULT, if1.ZERO, if1.COUT, busy_n1);
`else
                score(1, if1.RESULT, 1'b0, 1'b0, busy_n1);
`endif
                busy_n1 = 0;
            end
        end
    end

    // Monitor for the STEP=3 unit.
    initial forever begin
        @(negedge clk);
        if (!rst3) begin
            if (if3.BUSY) busy_n3++;
            if (if3.DONE) begin
`ifdef SHIFT_SEQ_FLAGS_EN
                score(3, if3.RESULT, if3.ZERO, if3.COUT, busy_n3);
`else
                score(3, if3.RESULT, 1'b0, 1'b0, busy_n3);
`endif
                busy_n3 = 0;
            end
        end
    end

    task automatic drive(input int u, input logic st, input logic [1:0] op,
                         input logic [7:0] d, input logic [7:0] s);
        if (u == 1) begin
            if1.START = st; if1.OP = op; if1.DATA = d; if1.SHIFT = s;
        end else begin
            if3.START = st; if3.OP = op; if3.DATA = d; if3.SHIFT = s;
        end
    endtask

    task automatic issue(input int u, input logic [1:0] op, input logic [7:0] d,
                         input logic [7:0] s, input logic [7:0] res, input int lat,
                         input int busy, input logic c);
        exp_t e;
        @(negedge clk);
        drive(u, 1'b1, op, d, s);
        @(posedge clk);
        #1;
        e.res = res; e.lat = lat; e.busy = busy; e.z = (res == 8'h00); e.c = c; e.t0 = cyc;
        if (u == 1) q1.push_back(e); else q3.push_back(e);
        @(negedge clk);
        drive(u, 1'b0, op, d, s);
    endtask

    task automatic wait_done(input int u);
        int sz;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #2;
            sz = (u == 1) ? q1.size() : q3.size();
            if (sz == 0) return;
        end
        chk($sformatf("u%0d_timeout_pending", u), sz, 0);
        if (u == 1) q1.delete(); else q3.delete();
    endtask

    initial begin
        drive(1, 1'b0, 2'b00, 8'h00, 8'h00);
        drive(3, 1'b0, 2'b00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("u1_reset_busy", if1.BUSY, 0);
        chk("u1_reset_done", if1.DONE, 0);
        chk("u1_reset_result", if1.RESULT, 8'h00);
        chk("u3_reset_busy", if3.BUSY, 0);
        chk("u3_reset_done", if3.DONE, 0);
        chk("u3_reset_result", if3.RESULT, 8'h00);
        @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;

        // STEP=1: SLL, then a START pulse during RUN that must be ignored.
        issue(1, 2'b00, 8'h35, 8'd3, 8'hA8, 4, 3, 1'b1);
        drive(1, 1'b1, 2'b01, 8'hFF, 8'd1);
        @(negedge clk);
        drive(1, 1'b0, 2'b01, 8'hFF, 8'd1);
        wait_done(1);
        // START in the DONE cycle is dropped; the next one is taken in IDLE.
        drive(1, 1'b1, 2'b11, 8'hC3, 8'd2);
        issue(1, 2'b10, 8'h90, 8'd2, 8'hE4, 3, 2, 1'b0);
        wait_done(1);
        issue(1, 2'b10, 8'h90, 8'd200, 8'hFF, 9, 8, 1'b1);
        wait_done(1);
        issue(1, 2'b01, 8'h90, 8'd200, 8'h00, 9, 8, 1'b1);
        wait_done(1);
        issue(1, 2'b00, 8'hFF, 8'd8, 8'h00, 9, 8, 1'b1);
        wait_done(1);
        issue(1, 2'b11, 8'h35, 8'd255, 8'h6A, 8, 7, 1'b0);
        wait_done(1);
        issue(1, 2'b00, 8'h5A, 8'd0, 8'h5A, 1, 0, 1'b0);
        wait_done(1);
        issue(1, 2'b00, 8'h80, 8'd1, 8'h00, 2, 1, 1'b1);
        wait_done(1);

        // Reset in the middle of RUN aborts the operation.
        issue(1, 2'b10, 8'h90, 8'd200, 8'hFF, 9, 8, 1'b1);
        repeat (3) @(negedge clk);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        chk("u1_midrun_reset_busy", if1.BUSY, 0);
        chk("u1_midrun_reset_done", if1.DONE, 0);
        chk("u1_midrun_reset_result", if1.RESULT, 8'h00);
        @(negedge clk);
        rst1 = 1'b0;
        q1.delete();
        busy_n1 = 0;
        issue(1, 2'b01, 8'hF0, 8'd4, 8'h0F, 5, 4, 1'b0);
        wait_done(1);

        // STEP=3 unit.
        issue(3, 2'b11, 8'h81, 8'd9, 8'hC0, 2, 1, 1'b1);
        wait_done(3);
        issue(3, 2'b00, 8'h01, 8'd7, 8'h80, 4, 3, 1'b0);
        wait_done(3);
        issue(3, 2'b11, 8'h01, 8'd5, 8'h08, 3, 2, 1'b0);
        wait_done(3);
        issue(3, 2'b10, 8'h40, 8'd9, 8'h00, 4, 3, 1'b0);
        wait_done(3);
        issue(3, 2'b10, 8'h90, 8'd200, 8'hFF, 4, 3, 1'b1);
        wait_done(3);
        issue(3, 2'b11, 8'h5A, 8'd0, 8'h5A, 1, 0, 1'b0);
        wait_done(3);
        issue(3, 2'b10, 8'h5A, 8'd0, 8'h5A, 1, 0, 1'b0);
        wait_done(3);

        repeat (5) @(negedge clk);
        chk("u1_queue_drained", q1.size(), 0);
        chk("u3_queue_drained", q3.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
